// File: rtl/bcd_serial_adder_pkg.sv
// Shared BCD constants, FSM state encoding and digit-validity helper for the
// digit-serial BCD adder.
package bcd_serial_adder_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] BCD_CORR = 4'd6;
    localparam logic [BCD_W-1:0] BCD_ONE  = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CARRY = 2'd2
    } state_t;

    function automatic logic bcd_invalid(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_adder_digit_add.sv
// Combinational single-digit BCD adder: binary add, then +6 correction when the
// binary sum exceeds 9.
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [BCD_W-1:0] a,
    input  logic [BCD_W-1:0] b,
    input  logic             cin,
    output logic [BCD_W-1:0] digit,
    output logic             cout
);

    logic [BCD_W:0] sum_s;
    logic [BCD_W:0] corr_s;

    // Binary sum and decimal correction; only the low nibble of corr_s is used,
    // so its wrap for large invalid-digit sums is harmless.
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        corr_s = sum_s + {1'b0, BCD_CORR};
        if (sum_s > {1'b0, BCD_MAX}) begin
            digit = corr_s[BCD_W-1:0];
            cout  = 1'b1;
        end else begin
            digit = sum_s[BCD_W-1:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder, LSD first, with a single registered output slot and
// an extra final-carry digit emitted from the CARRY state.
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BCD_W-1:0] in_a,
    input  logic [BCD_W-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BCD_W-1:0] out_digit,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_err
);

    state_t             state_q,     state_d;
    logic               carry_q,     carry_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic               out_valid_q, out_valid_d;
    logic [BCD_W-1:0]   out_digit_q, out_digit_d;
    logic               out_last_q,  out_last_d;
    logic [IDX_W-1:0]   out_idx_q,   out_idx_d;
    logic               out_err_q,   out_err_d;

    logic               acc_s;
    logic               pop_s;
    logic               slot_free_s;
    logic [BCD_W-1:0]   sum_digit_s;
    logic               sum_cout_s;

    bcd_digit_add u_digit_add (
        .a     (in_a),
        .b     (in_b),
        .cin   (carry_q),
        .digit (sum_digit_s),
        .cout  (sum_cout_s)
    );

    assign slot_free_s = !out_valid_q || out_ready;
    assign in_ready    = (state_q != ST_CARRY) && slot_free_s;
    assign acc_s       = in_valid && in_ready;
    assign pop_s       = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign out_err   = out_err_q;

    // Next-state logic for the FSM, carry/index counters and output slot.
    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_digit_d = out_digit_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        out_err_d   = out_err_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (acc_s) begin
                    out_valid_d = 1'b1;
                    out_digit_d = sum_digit_s;
                    out_idx_d   = idx_q;
                    out_err_d   = bcd_invalid(in_a) || bcd_invalid(in_b);
                    out_last_d  = in_last && !sum_cout_s;
                    if (!in_last) begin
                        state_d = ST_RUN;
                        carry_d = sum_cout_s;
                        idx_d   = idx_q + IDX_W'(1);
                    end else if (sum_cout_s) begin
                        // Carry out of the MSD becomes its own digit next.
                        state_d = ST_CARRY;
                        carry_d = 1'b0;
                        idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        carry_d = 1'b0;
                        idx_d   = {IDX_W{1'b0}};
                    end
                end else if (pop_s) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            ST_CARRY: begin
                if (slot_free_s) begin
                    out_valid_d = 1'b1;
                    out_digit_d = BCD_ONE;
                    out_last_d  = 1'b1;
                    out_err_d   = 1'b0;
                    out_idx_d   = idx_q;
                    state_d     = ST_IDLE;
                    carry_d     = 1'b0;
                    idx_d       = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_CARRY;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                carry_d     = 1'b0;
                idx_d       = {IDX_W{1'b0}};
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output-slot registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            carry_q     <= 1'b0;
            idx_q       <= {IDX_W{1'b0}};
            out_valid_q <= 1'b0;
            out_digit_q <= {BCD_W{1'b0}};
            out_last_q  <= 1'b0;
            out_idx_q   <= {IDX_W{1'b0}};
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed digit sequences plus
// randomized numbers, compared against a transaction-level model every cycle.
module tb_bcd_serial_adder;

    localparam int IDX_W = 3;
    localparam int IDX_MOD = 1 << IDX_W;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_digit;
    logic             out_last;
    logic [IDX_W-1:0] out_idx;
    logic             out_err;

    bcd_serial_adder #(.IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .out_err   (out_err)
    );

    typedef struct {
        int d;
        int l;
        int ix;
        int e;
    } ent_t;

    int   checks   = 0;
    int   failures = 0;
    bit   rand_rdy = 1'b0;

    ent_t slot[$];
    ent_t log_q[$];
    int   m_carry    = 0;
    int   m_idx      = 0;
    bit   carry_pend = 1'b0;
    int   pend_idx   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: one output slot, a pending final-carry digit, and the
    // decimal digit-add rule applied to each accepted pair.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                slot.delete();
                m_carry    = 0;
                m_idx      = 0;
                carry_pend = 1'b0;
            end else begin
                bit ev;
                bit erdy;
                ev   = (slot.size() != 0);
                erdy = !carry_pend && (!ev || out_ready);
                check("out_valid", int'(out_valid), int'(ev));
                check("in_ready", int'(in_ready), int'(erdy));
                if (ev) begin
                    check("out_digit", int'(out_digit), slot[0].d);
                    check("out_last", int'(out_last), slot[0].l);
                    check("out_idx", int'(out_idx), slot[0].ix);
                    check("out_err", int'(out_err), slot[0].e);
                    if (out_ready) begin
                        log_q.push_back(slot[0]);
                        slot.delete();
                    end
                end
                if (in_valid && erdy) begin
                    int s;
                    int c;
                    ent_t en;
                    s    = int'(in_a) + int'(in_b) + m_carry;
                    c    = (s > 9) ? 1 : 0;
                    en.d = (s > 9) ? ((s + 6) % 16) : s;
                    en.l = (in_last && c == 0) ? 1 : 0;
                    en.ix = m_idx;
                    en.e = (in_a > 4'd9 || in_b > 4'd9) ? 1 : 0;
                    slot.push_back(en);
                    if (in_last) begin
                        if (c == 1) begin
                            carry_pend = 1'b1;
                            pend_idx   = (m_idx + 1) % IDX_MOD;
                        end
                        m_idx   = 0;
                        m_carry = 0;
                    end else begin
                        m_idx   = (m_idx + 1) % IDX_MOD;
                        m_carry = c;
                    end
                end else if (carry_pend && slot.size() == 0) begin
                    ent_t en;
                    en.d = 1; en.l = 1; en.ix = pend_idx; en.e = 0;
                    slot.push_back(en);
                    carry_pend = 1'b0;
                end
            end
        end
    end

    task automatic send(input int a, input int b, input bit last);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 4'(a);
        in_b     = 4'(b);
        in_last  = last;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        for (int t = 0; t < 200 && !done; t++) begin
            @(posedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (slot.size() == 0 && !carry_pend) done = 1'b1;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    task automatic chk_log(input string name, input int k, input int d,
                           input int l, input int ix, input int e);
        if (k >= log_q.size()) begin
            check({name, "_missing"}, log_q.size(), k + 1);
        end else begin
            check({name, "_digit"}, log_q[k].d, d);
            check({name, "_last"}, log_q[k].l, l);
            check({name, "_idx"}, log_q[k].ix, ix);
            check({name, "_err"}, log_q[k].e, e);
        end
    endtask

    task automatic chk_t1(input string name);
        check({name, "_count"}, log_q.size(), 4);
        chk_log(name, 0, 2, 0, 0, 0);
        chk_log(name, 1, 6, 0, 1, 0);
        chk_log(name, 2, 5, 0, 2, 0);
        chk_log(name, 3, 0, 1, 3, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 4'd0;
        in_b      = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_digit", int'(out_digit), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_err", int'(out_err), 0);
        rst_n = 1'b1;

        // 347 + 215 = 562
        log_q.delete();
        send(7, 5, 0); send(4, 1, 0); send(3, 2, 0); send(0, 0, 1);
        drain();
        chk_t1("t1");

        // 999 + 001 = 1000
        log_q.delete();
        send(9, 1, 0); send(9, 0, 0); send(9, 0, 1);
        drain();
        check("t2_count", log_q.size(), 4);
        chk_log("t2", 0, 0, 0, 0, 0);
        chk_log("t2", 1, 0, 0, 1, 0);
        chk_log("t2", 2, 0, 0, 2, 0);
        chk_log("t2", 3, 1, 1, 3, 0);

        // Test 1 again with a 3-cycle consumer stall
        log_q.delete();
        fork
            begin
                send(7, 5, 0); send(4, 1, 0); send(3, 2, 0); send(0, 0, 1);
            end
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        chk_t1("t3");

        // Invalid digit 12 + 3
        log_q.delete();
        send(12, 3, 1);
        drain();
        check("t4_count", log_q.size(), 2);
        chk_log("t4", 0, 5, 0, 0, 1);
        chk_log("t4", 1, 1, 1, 1, 0);

        // Reset in the middle of a number
        send(9, 9, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("t5_rst_out_valid", int'(out_valid), 0);
        check("t5_rst_out_idx", int'(out_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        send(1, 1, 1);
        drain();
        check("t5_count", log_q.size(), 1);
        chk_log("t5", 0, 2, 1, 0, 0);

        // Index wrap across nine digits
        log_q.delete();
        for (int i = 0; i < 9; i++) send(0, 0, (i == 8));
        drain();
        check("t6_count", log_q.size(), 9);
        for (int i = 0; i < 9; i++) chk_log("t6", i, 0, (i == 8) ? 1 : 0, i % IDX_MOD, 0);

        // Randomized numbers, occasional invalid digits, random backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int len;
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++) begin
                int a;
                int b;
                a = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
                b = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
                send(a, b, (k == len - 1));
                if ($urandom_range(0, 5) == 0) begin
                    @(negedge clk);
                    in_valid  = 1'b0;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        rand_rdy = 1'b0;
        drain();
        check("final_slot_empty", slot.size(), 0);
        check("final_carry_pend", int'(carry_pend), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
